// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the master of the memory write bus and consumes the byte stream.
interface prog_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WIDTH-1:0]  imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a framed program over a byte stream
// (0xA5, word count, little-endian words, XOR checksum), writes each
// completed word into the core's instruction memory and releases the
// core from reset only after a frame with a good checksum.
module prog_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam logic [7:0] MAGIC     = 8'hA5;
  localparam logic [8:0] DEPTH_MAX = 9'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  len_q;
  logic [7:0]  word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  chk_q;
  logic [23:0] word_buf_q;

  logic accept;
  logic is_magic;
  logic len_bad;
  logic last_byte;
  logic last_word;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign is_magic  = (bus.rx_data == MAGIC);
  assign len_bad   = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > DEPTH_MAX);
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = (word_cnt_q == (len_q - 8'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and status outputs derived from the current state
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_magic) state_d = LEN;
      end
      LEN: begin
        busy = 1'b1;
        if (accept) state_d = len_bad ? ERR : DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (accept && last_byte && last_word) state_d = CHK;
      end
      CHK: begin
        busy = 1'b1;
        if (accept) state_d = (bus.rx_data == chk_q) ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (accept && is_magic) state_d = LEN;
      end
      ERR: begin
        err = 1'b1;
        if (accept && is_magic) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: word assembly, checksum, memory write strobe and core reset
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q          <= 8'd0;
      word_cnt_q     <= 8'd0;
      byte_cnt_q     <= 2'd0;
      chk_q          <= 8'd0;
      word_buf_q     <= 24'd0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rst        <= 1'b1;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.imem_we  <= 1'b0;
      cpu_rst      <= (state_q != DONE);
      if (accept) begin
        case (state_q)
          LEN: begin
            if (!len_bad) begin
              len_q      <= bus.rx_data;
              word_cnt_q <= 8'd0;
              byte_cnt_q <= 2'd0;
              chk_q      <= 8'd0;
            end
          end
          DATA: begin
            chk_q      <= chk_q ^ bus.rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: word_buf_q[7:0]   <= bus.rx_data;
              2'd1: word_buf_q[15:8]  <= bus.rx_data;
              2'd2: word_buf_q[23:16] <= bus.rx_data;
              default: begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_cnt_q[ADDR_W-1:0];
                bus.imem_wdata <= WIDTH'({bus.rx_data, word_buf_q});
                word_cnt_q     <= word_cnt_q + 8'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stimulus pushes expected memory writes
// into a queue, a monitor pops and compares each imem_we pulse, and status
// outputs are checked at hand-computed points in each frame.
module tb_prog_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst;
  logic cpu_rst;
  logic busy;
  logic done;
  logic err;

  int  n_checks;
  int  n_fail;
  wr_t exp_q[$];

  prog_loader_if #(.WIDTH(32), .ADDR_W(ADDR_W)) bus ();

  prog_loader #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one byte; it is accepted at the next rising edge
  task automatic apply_stimulus(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Memory-write monitor: every strobe must match the next expected write
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_we: got addr %0d data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("we_addr", 32'(bus.imem_addr), 32'(e.addr));
        check_output("we_data", bus.imem_wdata, e.data);
      end
    end
  end

  // Directed frame sequence
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("rst_status", {29'd0, busy, done, err}, 32'd0);
    check_output("rst_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_output("rst_wdata", bus.imem_wdata, 32'd0);
    rst = 1'b0;
    idle_cycles(1);
    check_output("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Garbage before the magic byte is ignored
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    apply_stimulus(8'h5A);
    check_output("garbage_idle", {29'd0, busy, done, err}, 32'd0);

    // Single-word frame with a correct checksum
    expect_write(6'd0, 32'h00500113);
    apply_stimulus(8'hA5);
    check_output("magic_busy", 32'(busy), 32'd1);
    apply_stimulus(8'h01);
    apply_stimulus(8'h13);
    apply_stimulus(8'h01);
    idle_cycles(3);
    check_output("gap_busy", 32'(busy), 32'd1);
    apply_stimulus(8'h50);
    apply_stimulus(8'h00);
    apply_stimulus(8'h42);
    check_output("single_done", 32'(done), 32'd1);
    check_output("single_cpu_rst_lag", 32'(cpu_rst), 32'd1);
    idle_cycles(1);
    check_output("single_cpu_rst_low", 32'(cpu_rst), 32'd0);

    // Reload from DONE: non-magic ignored, magic restarts and re-asserts core reset
    apply_stimulus(8'h5A);
    check_output("done_ignore", 32'(done), 32'd1);
    apply_stimulus(8'hA5);
    check_output("reload_done", 32'(done), 32'd0);
    check_output("reload_busy", 32'(busy), 32'd1);
    idle_cycles(1);
    check_output("reload_cpu_rst", 32'(cpu_rst), 32'd1);

    // Three words, valid held high throughout
    expect_write(6'd0, 32'h00500113);
    expect_write(6'd1, 32'h00C00193);
    expect_write(6'd2, 32'hFF718393);
    apply_stimulus(8'h03);
    apply_stimulus(8'h13); apply_stimulus(8'h01); apply_stimulus(8'h50); apply_stimulus(8'h00);
    apply_stimulus(8'h93); apply_stimulus(8'h01); apply_stimulus(8'hC0); apply_stimulus(8'h00);
    apply_stimulus(8'h93); apply_stimulus(8'h83); apply_stimulus(8'h71); apply_stimulus(8'hFF);
    apply_stimulus(8'h8E);
    check_output("multi_done", 32'(done), 32'd1);
    idle_cycles(2);
    check_output("multi_cpu_rst", 32'(cpu_rst), 32'd0);
    check_output("hold_wdata", bus.imem_wdata, 32'hFF718393);
    check_output("hold_addr", 32'(bus.imem_addr), 32'd2);

    // Bad checksum: word still written, then ERR
    expect_write(6'd0, 32'h00500113);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h13);
    apply_stimulus(8'h01);
    apply_stimulus(8'h50);
    apply_stimulus(8'h00);
    apply_stimulus(8'h43);
    check_output("badchk_err", 32'(err), 32'd1);
    check_output("badchk_busy", 32'(busy), 32'd0);
    idle_cycles(1);
    check_output("badchk_cpu_rst", 32'(cpu_rst), 32'd1);
    apply_stimulus(8'hA5);
    check_output("err_reload_busy", 32'(busy), 32'd1);
    check_output("err_reload_err", 32'(err), 32'd0);

    // Length bounds
    apply_stimulus(8'h00);
    check_output("len0_err", 32'(err), 32'd1);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h41);
    check_output("len65_err", 32'(err), 32'd1);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h40);
    check_output("len64_busy", 32'(busy), 32'd1);
    check_output("len64_err", 32'(err), 32'd0);

    // Reset after two data bytes abandons the frame
    apply_stimulus(8'h13);
    apply_stimulus(8'h01);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_output("midrst_status", {29'd0, busy, done, err}, 32'd0);
    check_output("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("midrst_wdata", bus.imem_wdata, 32'd0);
    rst = 1'b0;
    idle_cycles(1);
    check_output("midrst_resume_ready", 32'(bus.rx_ready), 32'd1);
    check_output("midrst_resume_idle", {29'd0, busy, done, err}, 32'd0);

    // Fresh frame after reset completes normally
    expect_write(6'd0, 32'h00500113);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h13);
    apply_stimulus(8'h01);
    apply_stimulus(8'h50);
    apply_stimulus(8'h00);
    apply_stimulus(8'h42);
    check_output("fresh_done", 32'(done), 32'd1);
    idle_cycles(3);
    check_output("fresh_cpu_rst", 32'(cpu_rst), 32'd0);
    check_output("writes_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
